// File: rtl/pipe_pkg.sv
// Shared definitions for pipe_stage_hs: default bubble value, counter width,
// saturating increment helper and control-field bit positions.
package pipe_pkg;

    localparam int unsigned DEF_CNT_W    = 32;
    localparam logic [15:0] DEF_CTRL_BUB = '0;

    // Control payload layout used by the core stages
    localparam int unsigned WBEN_BIT    = 0;
    localparam int unsigned IS_JAL_BIT  = 1;
    localparam int unsigned IS_JALR_BIT = 2;
    localparam int unsigned IS_BRC_BIT  = 3;
    localparam int unsigned DIVEN_BIT   = 4;
    localparam int unsigned DIVSEL_LSB  = 5;

    // Increment v unless it already sits at max; callers pass their own all-ones
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max);
        return (v >= max) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer with registered s_ready; passes through when empty and
// parks one beat when the downstream register cannot take it.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [CTRL_W-1:0] s_ctrl,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CTRL_W-1:0] m_ctrl,
    output logic [DATA_W-1:0] m_data
);

    logic              full;
    logic              full_nxt;
    logic              s_xfer;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign s_xfer  = s_valid & s_ready;
    assign m_valid = full | s_xfer;
    assign m_ctrl  = full ? skid_ctrl : s_ctrl;
    assign m_data  = full ? skid_data : s_data;

    always_comb begin
        full_nxt = full;
        if (flush) begin
            full_nxt = 1'b0;
        end else if (full && m_ready) begin
            full_nxt = 1'b0;
        end else if (s_xfer && !m_ready) begin
            full_nxt = 1'b1;
        end
    end

    // s_ready drops for one cycle after flush so nothing lands during the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= 1'b0;
            s_ready   <= 1'b1;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            full    <= full_nxt;
            s_ready <= ~full_nxt & ~flush;
            if (s_xfer && !m_ready && !full) begin
                skid_ctrl <= s_ctrl;
                skid_data <= s_data;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// Parametrised pipeline-stage register with valid/ready handshake, flush, hold
// and saturating stall/bubble counters. Define PIPE_SKID_BUF_EN for a registered in_ready.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W   = 256,
    parameter int unsigned       CTRL_W   = 16,
    parameter logic [CTRL_W-1:0] CTRL_BUB = CTRL_W'(DEF_CTRL_BUB),
    parameter int unsigned       CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              hold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [63:0] CNT_MAX = 64'({CNT_W{1'b1}});

    logic              out_xfer;
    logic              load_xfer;
    logic [CTRL_W-1:0] ld_ctrl;
    logic [DATA_W-1:0] ld_data;

    assign out_xfer = out_valid & out_ready & ~hold;

`ifdef PIPE_SKID_BUF_EN
    logic load_en;
    logic skid_valid;

    // Output register refills whenever it is empty or draining; hold only gates out_xfer
    assign load_en   = ~out_valid | out_xfer;
    assign load_xfer = skid_valid & load_en;

    pipe_skid_buf #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .s_valid (in_valid),
        .s_ready (in_ready),
        .s_ctrl  (in_ctrl),
        .s_data  (in_data),
        .m_valid (skid_valid),
        .m_ready (load_en),
        .m_ctrl  (ld_ctrl),
        .m_data  (ld_data)
    );
`else
    assign in_ready  = ~hold & (~out_valid | out_ready);
    assign load_xfer = in_valid & in_ready;
    assign ld_ctrl   = in_ctrl;
    assign ld_data   = in_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ctrl  <= CTRL_BUB;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_ctrl  <= CTRL_BUB;
        end else if (load_xfer) begin
            out_valid <= 1'b1;
            out_ctrl  <= ld_ctrl;
            out_data  <= ld_data;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
            out_ctrl  <= CTRL_BUB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_xfer && !flush) begin
                stall_cnt <= CNT_W'(sat_inc(64'(stall_cnt), CNT_MAX));
            end
            if (!out_valid) begin
                bubble_cnt <= CNT_W'(sat_inc(64'(bubble_cnt), CNT_MAX));
            end
        end
    end

endmodule
